// File: rtl/cla_adder_pipe_32bit.sv
// rtl/cla_adder_pipe_32bit.sv - two-stage pipelined 32-bit carry-lookahead adder/subtractor
// Lower 16 bits resolve in stage 1, upper 16 bits in stage 2 from the registered c16.

module lookahead_carry_generator_4bit (
   input  logic [3:0] g,
   input  logic [3:0] p,
   input  logic       c0,
   output logic [2:0] c,
   output logic       gg,
   output logic       pg
);

   // c[i] is the carry into bit i+1; the carry out of the group is gg | pg & c0
   assign c[0] = g[0] | (p[0] & c0);
   assign c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
   assign c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
   assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   assign pg   = &p;

endmodule

module cla_16bit #(
   parameter int HALF_W = 16,
   parameter int GRP_W  = 4
) (
   input  logic [HALF_W-1:0] a,
   input  logic [HALF_W-1:0] b,
   input  logic              cin,
   output logic [HALF_W-1:0] sum,
   output logic              cout,
   output logic              c_msb
);

   localparam int NGRP = HALF_W / GRP_W;

   logic [HALF_W-1:0] g;
   logic [HALF_W-1:0] p;
   logic [HALF_W:0]   c;
   logic [NGRP-1:0]   grp_g;
   logic [NGRP-1:0]   grp_p;
   logic [NGRP-1:0]   grp_cin;
   logic [NGRP-2:0]   lvl2_c;
   logic              blk_g;
   logic              blk_p;

   assign g = a & b;
   assign p = a ^ b;

   // Second level resolves every group carry-in directly from cin
   lookahead_carry_generator_4bit u_lvl2 (
      .g  (grp_g),
      .p  (grp_p),
      .c0 (cin),
      .c  (lvl2_c),
      .gg (blk_g),
      .pg (blk_p)
   );

   assign grp_cin = {lvl2_c, cin};

   for (genvar k = 0; k < NGRP; k++) begin : g_grp
      logic [GRP_W-2:0] c_in_grp;

      lookahead_carry_generator_4bit u_grp (
         .g  (g[k*GRP_W +: GRP_W]),
         .p  (p[k*GRP_W +: GRP_W]),
         .c0 (grp_cin[k]),
         .c  (c_in_grp),
         .gg (grp_g[k]),
         .pg (grp_p[k])
      );

      assign c[k*GRP_W]                  = grp_cin[k];
      assign c[k*GRP_W+1 +: GRP_W-1]     = c_in_grp;
   end

   assign c[HALF_W] = blk_g | (blk_p & cin);
   assign sum       = p ^ c[HALF_W-1:0];
   assign cout      = c[HALF_W];
   assign c_msb     = c[HALF_W-1];

endmodule

module cla_adder_pipe_32bit #(
   parameter int DATA_W = 32,
   parameter int HALF_W = DATA_W / 2,
   parameter int GRP_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              cin,
   input  logic              sub,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] sum,
   output logic              cout,
   output logic              ovf,
   output logic              zero
);

   logic [DATA_W-1:0] b_eff;
   logic              c_eff;
   logic [HALF_W-1:0] lo_sum;
   logic              lo_c16;
   logic              lo_c15_unused;

   logic              s1_valid;
   logic [HALF_W-1:0] s1_sum_lo;
   logic              s1_c16;
   logic [HALF_W-1:0] s1_a_hi;
   logic [HALF_W-1:0] s1_b_hi;

   logic [HALF_W-1:0] hi_sum;
   logic              hi_c32;
   logic              hi_c31;
   logic              s2_ready;
   logic              accept;

   // Subtract is a + ~b + 1; the caller's cin has no meaning then
   assign b_eff = sub ? ~b : b;
   assign c_eff = sub | cin;

   cla_16bit #(.HALF_W(HALF_W), .GRP_W(GRP_W)) u_cla_lo (
      .a     (a[HALF_W-1:0]),
      .b     (b_eff[HALF_W-1:0]),
      .cin   (c_eff),
      .sum   (lo_sum),
      .cout  (lo_c16),
      .c_msb (lo_c15_unused)
   );

   cla_16bit #(.HALF_W(HALF_W), .GRP_W(GRP_W)) u_cla_hi (
      .a     (s1_a_hi),
      .b     (s1_b_hi),
      .cin   (s1_c16),
      .sum   (hi_sum),
      .cout  (hi_c32),
      .c_msb (hi_c31)
   );

   assign s2_ready = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_ready;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_sum_lo <= '0;
         s1_c16    <= 1'b0;
         s1_a_hi   <= '0;
         s1_b_hi   <= '0;
      end else if (in_ready) begin
         s1_valid <= accept;
         if (accept) begin
            s1_sum_lo <= lo_sum;
            s1_c16    <= lo_c16;
            s1_a_hi   <= a[DATA_W-1:HALF_W];
            s1_b_hi   <= b_eff[DATA_W-1:HALF_W];
         end
      end
   end

   // Result registers only move on a real stage-2 load, so they hold through stalls and bubbles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
      end else if (s2_ready) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            sum  <= {hi_sum, s1_sum_lo};
            cout <= hi_c32;
            ovf  <= hi_c31 ^ hi_c32;
            zero <= ~|{hi_sum, s1_sum_lo};
         end
      end
   end

endmodule
